// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the debounced key code handed to the calculator input register.
// The master side is the scanner; the slave side is the keypad/consumer.
interface keypad_scanner_if;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] num;
   logic       numPressed;

   modport master (input col, output row, output num, output numPressed);
   modport slave  (output col, input row, input num, input numPressed);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low row per slot, debounces press and release,
// and presents a key code that is stable before, during and after the numPressed level.
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 10
) (
   input  logic             clk,
   input  logic             reset,
   keypad_scanner_if.master kp
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2
   } state_t;

   logic [DIV_W-1:0] r_div;
   logic [3:0]       r_col_meta;
   logic [3:0]       r_col_sync;
   state_t           r_state;
   logic [1:0]       r_row_idx;
   logic [1:0]       r_cand_row;
   logic [1:0]       r_cand_col;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_num;
   logic             r_num_pressed;

   logic             w_tick;
   logic             w_col_valid;
   logic [1:0]       w_col_idx;
   logic [3:0]       w_cand_pat;
   logic [CNT_W-1:0] w_cnt_inc;
   state_t           w_state_nxt;
   logic [1:0]       w_row_idx_nxt;
   logic [1:0]       w_cand_row_nxt;
   logic [1:0]       w_cand_col_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [3:0]       w_num_nxt;
   logic             w_num_pressed_nxt;

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      code = 4'd0;
      case ({r, c})
         4'd0:  code = 4'd1;
         4'd1:  code = 4'd2;
         4'd2:  code = 4'd3;
         4'd3:  code = 4'd10;
         4'd4:  code = 4'd4;
         4'd5:  code = 4'd5;
         4'd6:  code = 4'd6;
         4'd7:  code = 4'd11;
         4'd8:  code = 4'd7;
         4'd9:  code = 4'd8;
         4'd10: code = 4'd9;
         4'd11: code = 4'd12;
         4'd12: code = 4'd14;
         4'd13: code = 4'd0;
         4'd14: code = 4'd15;
         4'd15: code = 4'd13;
         default: code = 4'd0;
      endcase
      return code;
   endfunction

   assign w_tick     = (r_div == DIV_LAST);
   assign w_cand_pat = ~(4'b0001 << r_cand_col);
   assign w_cnt_inc  = r_cnt + CNT_W'(1);

   // Exactly one low column is a key; none or several low is treated as no key.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_col_valid = 1'b1;
      w_col_idx   = 2'd0;
      case (r_col_sync)
         4'b1110: w_col_idx = 2'd0;
         4'b1101: w_col_idx = 2'd1;
         4'b1011: w_col_idx = 2'd2;
         4'b0111: w_col_idx = 2'd3;
         default: w_col_valid = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_row_idx_nxt  = r_row_idx;
      w_cand_row_nxt = r_cand_row;
      w_cand_col_nxt = r_cand_col;
      w_cnt_nxt      = r_cnt;
      w_num_nxt      = r_num;
      case (r_state)
         SCAN: begin
            if (w_tick) begin
               if (w_col_valid) begin
                  w_cand_row_nxt = r_row_idx;
                  w_cand_col_nxt = w_col_idx;
                  w_cnt_nxt      = CNT_W'(1);
                  w_state_nxt    = PRESS_DB;
               end else begin
                  w_row_idx_nxt = r_row_idx + 2'd1;
               end
            end
         end
         PRESS_DB: begin
            if (w_tick) begin
               if (r_col_sync == w_cand_pat) begin
                  if (w_cnt_inc == CNT_DONE) begin
                     w_num_nxt   = key_code(r_cand_row, r_cand_col);
                     w_cnt_nxt   = '0;
                     w_state_nxt = HELD;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  w_cnt_nxt     = '0;
                  w_state_nxt   = SCAN;
                  w_row_idx_nxt = r_row_idx + 2'd1;
               end
            end
         end
         HELD: begin
            // Any low column while held (bounce or an extra key) restarts the release count.
            if (w_tick) begin
               if (r_col_sync == 4'b1111) begin
                  if (w_cnt_inc == CNT_DONE) begin
                     w_cnt_nxt     = '0;
                     w_row_idx_nxt = 2'd0;
                     w_state_nxt   = SCAN;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  w_cnt_nxt = '0;
               end
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = SCAN;
         end
      endcase
      // numPressed trails the num load by one edge and drops on the release-confirm edge.
      w_num_pressed_nxt = (r_state == HELD) && (w_state_nxt == HELD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div         <= '0;
         r_col_meta    <= 4'b1111;
         r_col_sync    <= 4'b1111;
         r_state       <= SCAN;
         r_row_idx     <= 2'd0;
         r_cand_row    <= 2'd0;
         r_cand_col    <= 2'd0;
         r_cnt         <= '0;
         r_num         <= 4'd0;
         r_num_pressed <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         r_div         <= w_tick ? '0 : r_div + DIV_W'(1);
         r_col_meta    <= kp.col;
         r_col_sync    <= r_col_meta;
         r_state       <= w_state_nxt;
         r_row_idx     <= w_row_idx_nxt;
         r_cand_row    <= w_cand_row_nxt;
         r_cand_col    <= w_cand_col_nxt;
         r_cnt         <= w_cnt_nxt;
         r_num         <= w_num_nxt;
         r_num_pressed <= w_num_pressed_nxt;
      end
   end

   assign kp.row        = ~(4'b0001 << r_row_idx);
   assign kp.num        = r_num;
   assign kp.numPressed = r_num_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a resistive-matrix keypad model (SCAN_DIV=4, DEBOUNCE_CNT=3).
module tb_keypad_scanner;

   localparam int SCAN_DIV      = 4;
   localparam int DEBOUNCE_CNT  = 3;
   localparam int PRESS_LIMIT   = (4 + DEBOUNCE_CNT) * SCAN_DIV + 3;
   localparam int RELEASE_LIMIT = (DEBOUNCE_CNT + 1) * SCAN_DIV + 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] keys = 16'h0000;
   logic [3:0]  w_col;
   int          checks = 0;
   int          failures = 0;

   keypad_scanner_if kp();

   keypad_scanner #(
      .SCAN_DIV    (SCAN_DIV),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .kp   (kp)
   );

   always #5 clk = ~clk;

   // A closed key at (r,c) pulls column c low while row r is driven low.
   always_comb begin
      w_col = 4'b1111;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[r*4+c] && !kp.row[r]) w_col[c] = 1'b0;
   end
   assign kp.col = w_col;

   task automatic set_key(input int r, input int c, input logic v);
      keys[r*4+c] = v;
   endtask

   task automatic wait_np(input logic level, input int limit, output int cycles);
      cycles = 0;
      while (kp.numPressed !== level && cycles <= limit) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      logic [3:0] prev_row;
      int         run;
      @(negedge clk);
      reset = 1'b1;
      keys  = 16'h0000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++;
      if (kp.row !== 4'b1110 || kp.num !== 4'd0 || kp.numPressed !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: row=%b num=%0d np=%b, expected row=1110 num=0 np=0",
                  kp.row, kp.num, kp.numPressed);
      end
      prev_row = 4'b1110;
      run      = 1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         checks++;
         if (kp.num !== 4'd0 || kp.numPressed !== 1'b0) begin
            failures++;
            $display("FAIL idle_outputs: cycle %0d num=%0d np=%b, expected num=0 np=0",
                     i, kp.num, kp.numPressed);
         end
         if (kp.row === prev_row) begin
            run++;
         end else begin
            checks++;
            if (kp.row !== {prev_row[2:0], prev_row[3]} || run != SCAN_DIV) begin
               failures++;
               $display("FAIL row_rotation: cycle %0d row=%b after %b held %0d, expected %b held 4",
                        i, kp.row, prev_row, run, {prev_row[2:0], prev_row[3]});
            end
            prev_row = kp.row;
            run      = 1;
         end
      end
   endtask

   task automatic test_press();
      int num_cycle;
      int rise_cycle;
      int cyc;
      num_cycle  = -1;
      rise_cycle = -1;
      set_key(2, 1, 1'b1);
      for (int n = 1; n <= PRESS_LIMIT + 5 && rise_cycle < 0; n++) begin
         @(negedge clk);
         if (num_cycle < 0 && kp.num === 4'd8) num_cycle = n;
         if (kp.numPressed === 1'b1) rise_cycle = n;
      end
      checks++;
      if (rise_cycle < 0 || rise_cycle > PRESS_LIMIT) begin
         failures++;
         $display("FAIL press_latency: rise at cycle %0d, expected 1..%0d", rise_cycle, PRESS_LIMIT);
      end
      checks++;
      if (kp.num !== 4'd8 || num_cycle != rise_cycle - 1) begin
         failures++;
         $display("FAIL press_num_lead: num=%0d set at %0d rise at %0d, expected num=8 one cycle before",
                  kp.num, num_cycle, rise_cycle);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++;
         if (kp.row !== 4'b1011 || kp.numPressed !== 1'b1) begin
            failures++;
            $display("FAIL press_hold_row: row=%b np=%b, expected row=1011 np=1", kp.row, kp.numPressed);
         end
      end
      set_key(2, 1, 1'b0);
      wait_np(1'b0, RELEASE_LIMIT, cyc);
      checks++;
      if (cyc > RELEASE_LIMIT) begin
         failures++;
         $display("FAIL press_release: np still %b after %0d cycles, expected 0", kp.numPressed, cyc);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_hold_release();
      int cyc;
      int drops;
      set_key(0, 0, 1'b1);
      wait_np(1'b1, PRESS_LIMIT, cyc);
      checks++;
      if (cyc > PRESS_LIMIT || kp.num !== 4'd1) begin
         failures++;
         $display("FAIL hold_press: rise after %0d cycles num=%0d, expected <=%0d num=1",
                  cyc, kp.num, PRESS_LIMIT);
      end
      drops = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (kp.numPressed !== 1'b1) drops++;
      end
      checks++;
      if (drops != 0) begin
         failures++;
         $display("FAIL hold_single_pulse: np low in %0d of 300 held cycles, expected 0", drops);
      end
      set_key(0, 0, 1'b0);
      wait_np(1'b0, RELEASE_LIMIT, cyc);
      checks++;
      if (cyc > RELEASE_LIMIT) begin
         failures++;
         $display("FAIL hold_release_latency: fall after %0d cycles, expected <=%0d", cyc, RELEASE_LIMIT);
      end
      drops = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (kp.num !== 4'd1 || kp.numPressed !== 1'b0) drops++;
      end
      checks++;
      if (drops != 0) begin
         failures++;
         $display("FAIL hold_num_retained: %0d cycles differ, num=%0d np=%b, expected num=1 np=0",
                  drops, kp.num, kp.numPressed);
      end
   endtask

   task automatic test_bounce();
      int         guard;
      int         rise_k;
      int         cyc;
      logic [3:0] num35;
      logic [3:0] num36;
      guard = 0;
      while (kp.row === 4'b0111 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      while (kp.row !== 4'b0111 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 40) begin
         failures++;
         $display("FAIL bounce_row3_wait: row=%b never reached 0111", kp.row);
      end
      set_key(3, 1, 1'b1);
      rise_k = -1;
      num35  = 4'hx;
      num36  = 4'hx;
      for (int k = 1; k <= 60 && rise_k < 0; k++) begin
         @(negedge clk);
         if (k == 8)  set_key(3, 1, 1'b0);
         if (k == 12) set_key(3, 1, 1'b1);
         if (k == 35) num35 = kp.num;
         if (k == 36) num36 = kp.num;
         if (kp.numPressed === 1'b1) rise_k = k;
      end
      checks++;
      if (rise_k != 37) begin
         failures++;
         $display("FAIL bounce_rise_time: rise at cycle %0d, expected 37", rise_k);
      end
      checks++;
      if (num35 !== 4'd1 || num36 !== 4'd0 || kp.num !== 4'd0) begin
         failures++;
         $display("FAIL bounce_num: num@35=%0d num@36=%0d num@rise=%0d, expected 1 0 0",
                  num35, num36, kp.num);
      end
      set_key(3, 1, 1'b0);
      wait_np(1'b0, RELEASE_LIMIT, cyc);
      checks++;
      if (cyc > RELEASE_LIMIT) begin
         failures++;
         $display("FAIL bounce_release: fall after %0d cycles, expected <=%0d", cyc, RELEASE_LIMIT);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_two_keys();
      logic [3:0] prev_row;
      int         changes;
      int         highs;
      int         cyc;
      set_key(1, 0, 1'b1);
      set_key(1, 2, 1'b1);
      prev_row = kp.row;
      changes  = 0;
      highs    = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (kp.row !== prev_row) changes++;
         if (kp.numPressed !== 1'b0) highs++;
         prev_row = kp.row;
      end
      checks++;
      if (highs != 0) begin
         failures++;
         $display("FAIL two_keys_ignored: np high in %0d cycles, expected 0", highs);
      end
      checks++;
      if (changes != 25) begin
         failures++;
         $display("FAIL two_keys_scanning: %0d row changes in 100 cycles, expected 25", changes);
      end
      set_key(1, 2, 1'b0);
      wait_np(1'b1, PRESS_LIMIT, cyc);
      checks++;
      if (cyc > PRESS_LIMIT || kp.num !== 4'd4) begin
         failures++;
         $display("FAIL two_keys_single: rise after %0d cycles num=%0d, expected <=%0d num=4",
                  cyc, kp.num, PRESS_LIMIT);
      end
      set_key(1, 0, 1'b0);
      wait_np(1'b0, RELEASE_LIMIT, cyc);
      checks++;
      if (cyc > RELEASE_LIMIT) begin
         failures++;
         $display("FAIL two_keys_release: fall after %0d cycles, expected <=%0d", cyc, RELEASE_LIMIT);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_mid_press();
      int cyc;
      set_key(1, 3, 1'b1);
      wait_np(1'b1, PRESS_LIMIT, cyc);
      checks++;
      if (cyc > PRESS_LIMIT || kp.num !== 4'd11) begin
         failures++;
         $display("FAIL midreset_press: rise after %0d cycles num=%0d, expected <=%0d num=11",
                  cyc, kp.num, PRESS_LIMIT);
      end
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (kp.numPressed !== 1'b0 || kp.num !== 4'd0 || kp.row !== 4'b1110) begin
         failures++;
         $display("FAIL midreset_values: np=%b num=%0d row=%b, expected np=0 num=0 row=1110",
                  kp.numPressed, kp.num, kp.row);
      end
      wait_np(1'b1, PRESS_LIMIT, cyc);
      checks++;
      if (cyc > PRESS_LIMIT || kp.num !== 4'd11) begin
         failures++;
         $display("FAIL midreset_redetect: rise after %0d cycles num=%0d, expected <=%0d num=11",
                  cyc, kp.num, PRESS_LIMIT);
      end
      set_key(1, 3, 1'b0);
      wait_np(1'b0, RELEASE_LIMIT, cyc);
      checks++;
      if (cyc > RELEASE_LIMIT) begin
         failures++;
         $display("FAIL midreset_release: fall after %0d cycles, expected <=%0d", cyc, RELEASE_LIMIT);
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_hold_release();
      test_bounce();
      test_two_keys();
      test_reset_mid_press();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, debounces presses and releases, and encodes the pressed key.
- Sits directly upstream of the calculator input register.
- Drives `num` (key code) and `numPressed` (clean level whose rising edge clocks the digit in).
- Guarantees `num` is stable before `numPressed` rises, and stays stable while it is high and after it falls.

Parameters:
- SCAN_DIV, 1000: clk cycles per row slot; one column sample ("tick") per slot. Must be >= 4.
- DEBOUNCE_CNT, 10: consecutive identical tick samples needed to confirm a press or a release. Must be >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- col  input  4  keypad column inputs, active-low (pulled up), asynchronous to clk
- row  output  4  keypad row drive, active-low one-hot
- num  output  4  encoded key code
- numPressed  output  1  high while a debounced key is held

Behaviour:
- One clock; reset is synchronous and active-high (sampled on posedge clk).
- Reset values:
  - row=4'b1110; num=0; numPressed=0.
  - Divider=0; sync flops=4'b1111; state=SCAN; row index=0; debounce count=0.
- Reset asserted mid-press or mid-debounce: all of the above on the next edge, `numPressed` drops immediately, no key reported.
- `col` passes through a 2-FF synchronizer (colS); all decisions use colS.
- Divider counts 0..SCAN_DIV-1 and wraps. tick = (divider==SCAN_DIV-1). It runs in every state.
- Key map, code at (row r, col c); c=0 is col[0]:
  - r0: 1,2,3,10
  - r1: 4,5,6,11
  - r2: 7,8,9,12
  - r3: 14,0,15,13
- Valid sample: colS has exactly one bit low. Zero or two-plus low bits is "no key"; multi-key is ignored.
- State SCAN:
  - On tick, if colS is valid: latch cand={row idx, col idx}, count=1, go PRESS_DB. Row is held.
  - Otherwise advance row idx (3 wraps to 0) and drive the next row from the following cycle.
- State PRESS_DB: on each tick:
  - colS equals the cand column pattern: count+1.
  - Otherwise: count=0, go SCAN and advance to the next row.
  - When count reaches DEBOUNCE_CNT: load num=map(cand) on that edge, go HELD.
  - numPressed=1 on the following clk edge, so num leads numPressed by exactly 1 cycle.
- State HELD: numPressed=1, row held. On each tick:
  - colS==4'b1111: count+1 (count restarts from 0 on entry to HELD).
  - Anything else: count=0. Covers bounce and a second key added.
  - When count reaches DEBOUNCE_CNT: numPressed=0 on that edge, row idx=0, go SCAN.
- `num` retains its value after release until the next confirmed press.
- Exactly one numPressed rising edge per physical press. Holding a key never re-triggers.
- A codes (10-15) are reported like digits; filtering is downstream.
- Latency, press applied (stable) to numPressed rise: at most (4+DEBOUNCE_CNT)*SCAN_DIV+3 cycles.
- Latency, release to numPressed fall: at most (DEBOUNCE_CNT+1)*SCAN_DIV+3 cycles.

Test Plan:
- Common setup: SCAN_DIV=4, DEBOUNCE_CNT=3; keypad model pulls col[c] low when row r is low and key (r,c) is closed.
- Reset, no key, 200 cycles:
  - row cycles 1110,1101,1011,0111 every 4 cycles.
  - num=0 and numPressed=0 throughout.
- Press key (r2,c1) stably:
  - num=8 exactly 1 cycle before numPressed rises, within 31 cycles.
  - row stays 1011 while held.
- Hold (r0,c0) for 300 cycles, then release:
  - a single numPressed pulse with num=1.
  - numPressed falls within 19 cycles of release.
  - num stays 1 afterwards.
- Bounce: press (r3,c1) and open it for 1 tick after 2 good ticks, then close it stably:
  - no numPressed until 3 consecutive good ticks.
  - then num=0, numPressed=1.
- Two keys (r1,c0)+(r1,c2) closed together:
  - numPressed stays 0 and scanning continues.
  - release c2: num=4 is reported.
- Assert reset for 1 cycle while (r1,c3) is held with numPressed=1:
  - next cycle numPressed=0, num=0, row=1110.
  - key still held: re-detected, num=11 with a fresh numPressed rise.
